apb_regfile_completer: RTL and testbench
========================================

# apb_regfile_completer

APB completer holding a small 32-bit register bank. It answers the transfers that the AXI4-Lite-to-APB bridge initiates on one `m_apb_psel` bit. It inserts a programmable number of wait states, honours byte strobes and flags bad accesses with `pslverr`. It is the far end of the bridge's APB port and serves both as a bench target for the bridge and as a reusable peripheral register block.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of register 0; must be 4-byte aligned.
- NUM_REGS, 16: number of 32-bit registers, 2..64.
- WAIT_STATES, 0: pready-low cycles inserted in each access phase, 0..15.
- ID_VALUE, 32'hA9B0_0001: constant returned by register 0, which is read-only.

Ports:
- s_axi_clk  in  1  clock; all logic is rising-edge.
- s_axi_aresetn  in  1  reset, asynchronous, active-low.
- psel  in  1  completer select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  32  byte address.
- pwdata  in  32  write data.
- pstrb  in  4  byte write strobes.
- pprot  in  3  protection attributes.
- pready  out  1  transfer complete.
- prdata  out  32  read data.
- pslverr  out  1  error response.
- regs_q  out  32*NUM_REGS  flat register contents; register k is at bits [32k+31:32k], register 0 = ID_VALUE.

## Operation
- States: IDLE, ACCESS.
- IDLE -> ACCESS when psel=1 and penable=0 (setup phase). At this edge:
  - wait counter loads WAIT_STATES;
  - decode result (index, err) is latched.
- ACCESS, psel=0: go to IDLE; abort, no write, no response.
- ACCESS, cnt!=0: cnt decrements each cycle.
- ACCESS, cnt==0: pready=1 for exactly one cycle, then IDLE.
- penable=1 seen in IDLE with no preceding setup is ignored: pready stays 0 and state stays IDLE.
- Decode: off = paddr - BASE_ADDR. err=1 when any of:
  - paddr < BASE_ADDR;
  - off >= 4*NUM_REGS;
  - paddr[1:0] != 0;
  - pwrite=1 to register 0;
  - the protection check fails (see Configuration).
- Write commit, at the edge ending the pready=1 cycle, only if err=0: byte b of the register updates from pwdata when pstrb[b]=1. pstrb=0 is a legal no-op write.
- Read: prdata = register[index] during the pready=1 cycle when err=0; otherwise prdata=0.
- pslverr = err during the pready=1 cycle, else 0. An erroring access never modifies any register.

## Timing
- Reset values:
  - pready=0, prdata=0, pslverr=0, state=IDLE;
  - registers 1..NUM_REGS-1 = 0.
- Reset deassertion takes effect on the next clock edge.
- Transfer length is 2+WAIT_STATES cycles: setup, WAIT_STATES wait cycles, then one ready cycle.
- Back-to-back transfers are legal: the setup for the next transfer may come in the cycle right after pready=1, giving zero idle cycles.
- pready, prdata and pslverr are combinational from state, counter and the latched decode only. There is no combinational path from paddr or pwdata to pready.
- Read-after-write to the same register in consecutive transfers returns the new value.
- Reset asserted mid-transfer: outputs go to their reset values immediately, no commit occurs, state is forced to IDLE.

## Configuration
- APB_COMPLETER_PROT_EN defined:
  - a transfer with pprot[0]=0 (unprivileged) to any register index >= NUM_REGS/2 sets err;
  - such a transfer completes with pslverr=1 and no write.
- Macro undefined: pprot is ignored and never causes an error.

## Structure
- Package apb_completer_pkg holds:
  - the state enum (IDLE, ACCESS);
  - the error-cause constants (ERR_RANGE, ERR_ALIGN, ERR_RO, ERR_PROT), used for debug visibility;
  - the function computing the register index width as $clog2(NUM_REGS).
- Sub-module apb_completer_decode is combinational. It takes paddr, pwrite and pprot and returns index and err. It is instantiated once; its outputs are latched at setup.

## Test plan
- WAIT_STATES=0: write 32'hDEAD_BEEF to BASE+4 with pstrb=4'hF, then read BASE+4. Required: pready high in the 2nd cycle of each transfer, prdata=32'hDEAD_BEEF, pslverr=0.
- WAIT_STATES=3: read BASE+0. Required: pready low for 3 access cycles then high, prdata=ID_VALUE.
- Partial strobe write:
  - with reg 2 = 32'h1122_3344, write pwdata=32'hAABB_CCDD with pstrb=4'b0101;
  - required read-back = 32'h11BB_33DD.
- Error cases, each with pslverr=1 and regs_q unchanged:
  - write to BASE+0;
  - read at BASE+4*NUM_REGS (prdata=0 required);
  - write to BASE+6 (misaligned).
- Abort: drop psel in the first wait cycle of a write to BASE+8 (WAIT_STATES=2). Required: no pready, reg 2 unchanged. An immediate new setup must still complete normally.
- Reset mid-transfer: assert s_axi_aresetn=0 during ACCESS. Required: pready/pslverr/prdata 0 in the same cycle, regs 1..NUM_REGS-1 = 0.
- With APB_COMPLETER_PROT_EN: write with pprot=3'b000 to index NUM_REGS-1. Required: pslverr=1, no write.

Source files
------------

// File: rtl/apb_completer_pkg.sv
// Shared types and constants for the APB register-file completer.
// Optional feature macro used by this slice: APB_COMPLETER_PROT_EN.
package apb_completer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // One-hot error causes, OR-ed together to form the error flag
  localparam logic [3:0] ERR_RANGE = 4'b0001;
  localparam logic [3:0] ERR_ALIGN = 4'b0010;
  localparam logic [3:0] ERR_RO    = 4'b0100;
  localparam logic [3:0] ERR_PROT  = 4'b1000;

  function automatic int idxWidth(input int numRegs);
    return $clog2(numRegs);
  endfunction

endpackage

// File: rtl/apb_completer_decode.sv
// Combinational address decode: register index and error flag for one APB access.
// Privilege check on the upper half of the bank only exists with APB_COMPLETER_PROT_EN.
module apb_completer_decode
  import apb_completer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_REGS  = 16,
  parameter int          IDXW      = 4
) (
  input  logic [31:0]     paddr_i,
  input  logic            pwrite_i,
  input  logic [2:0]      pprot_i,
  output logic [IDXW-1:0] index_o,
  output logic            err_o
);

  logic [31:0] off;
  logic [3:0]  cause;
  logic        inRange;
  logic        unusedProt;

  assign off        = paddr_i - BASE_ADDR;
  assign inRange    = (paddr_i >= BASE_ADDR) && (off < 32'(4 * NUM_REGS));
  assign index_o    = off[IDXW+1:2];
  assign unusedProt = ^pprot_i;

  // Index is only meaningful when the address lands inside the bank
  always_comb begin
    cause = '0;
    if (!inRange) cause = cause | ERR_RANGE;
    if (paddr_i[1:0] != 2'b00) cause = cause | ERR_ALIGN;
    if (inRange && pwrite_i && (index_o == '0)) cause = cause | ERR_RO;
`ifdef APB_COMPLETER_PROT_EN
    if (inRange && !pprot_i[0] && (index_o >= IDXW'(NUM_REGS / 2))) cause = cause | ERR_PROT;
`endif
  end

  assign err_o = |cause;

endmodule

// File: rtl/apb_regfile_completer.sv
// APB completer with a 32-bit register bank, programmable wait states and byte strobes.
// Build option: APB_COMPLETER_PROT_EN enables the privileged-upper-half check in the decoder.
module apb_regfile_completer
  import apb_completer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                    s_axi_clk,
  input  logic                    s_axi_aresetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [31:0]             paddr,
  input  logic [31:0]             pwdata,
  input  logic [3:0]              pstrb,
  input  logic [2:0]              pprot,
  output logic                    pready,
  output logic [31:0]             prdata,
  output logic                    pslverr,
  output logic [32*NUM_REGS-1:0]  regs_q
);

  localparam int IDXW = idxWidth(NUM_REGS);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q;
  logic            err_q;
  logic            write_q;
  logic [31:0]     regFile_q [1:NUM_REGS-1];

  logic [IDXW-1:0] decIdx;
  logic            decErr;
  logic            setupHit;
  logic            commit;
  logic [31:0]     readVal;

  apb_completer_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS),
    .IDXW      (IDXW)
  ) u_decode (
    .paddr_i  (paddr),
    .pwrite_i (pwrite),
    .pprot_i  (pprot),
    .index_o  (decIdx),
    .err_o    (decErr)
  );

  assign setupHit = (state_q == IDLE) && psel && !penable;

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (setupHit) begin
        idx_q   <= decIdx;
        err_q   <= decErr;
        write_q <= pwrite;
      end
    end
  end

  // Ready depends only on state and counter so paddr/pwdata never reach pready
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (setupHit) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          if (!psel) state_d = IDLE;
          else       cnt_d   = cnt_q - 4'd1;
        end else begin
          pready  = 1'b1;
          pslverr = err_q;
          prdata  = err_q ? 32'h0 : readVal;
          commit  = psel && write_q && !err_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int k = 1; k < NUM_REGS; k++) regFile_q[k] <= '0;
    end else begin
      for (int k = 1; k < NUM_REGS; k++) begin
        if (commit && (idx_q == IDXW'(k))) begin
          for (int b = 0; b < 4; b++) begin
            if (pstrb[b]) regFile_q[k][8*b +: 8] <= pwdata[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    regs_q        = '0;
    regs_q[31:0]  = ID_VALUE;
    for (int k = 1; k < NUM_REGS; k++) regs_q[32*k +: 32] = regFile_q[k];
  end

  always_comb begin
    readVal = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx_q == IDXW'(k)) readVal = regs_q[32*k +: 32];
    end
  end

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Self-checking bench: three completers (0, 2 and 3 wait states) against an array-based register model.
// Honours APB_COMPLETER_PROT_EN in the reference model.
module tb_apb_regfile_completer;

  localparam int          NR   = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] IDV  = 32'hA9B0_0001;
  localparam int          NDUT = 3;

  logic clock = 1'b0;
  logic resetN;
  always #5 clock = ~clock;

  logic        psel    [NDUT];
  logic        penable [NDUT];
  logic        pwrite  [NDUT];
  logic [31:0] paddr   [NDUT];
  logic [31:0] pwdata  [NDUT];
  logic [3:0]  pstrb   [NDUT];
  logic [2:0]  pprot   [NDUT];
  wire         preadyW  [NDUT];
  wire  [31:0] prdataW  [NDUT];
  wire         pslverrW [NDUT];
  wire  [32*NR-1:0] regsW [NDUT];

  logic [31:0] model [NDUT][NR];
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    apb_regfile_completer #(
      .BASE_ADDR   (BASE),
      .NUM_REGS    (NR),
      .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 2 : 3)),
      .ID_VALUE    (IDV)
    ) dut (
      .s_axi_clk     (clock),
      .s_axi_aresetn (resetN),
      .psel          (psel[g]),
      .penable       (penable[g]),
      .pwrite        (pwrite[g]),
      .paddr         (paddr[g]),
      .pwdata        (pwdata[g]),
      .pstrb         (pstrb[g]),
      .pprot         (pprot[g]),
      .pready        (preadyW[g]),
      .prdata        (prdataW[g]),
      .pslverr       (pslverrW[g]),
      .regs_q        (regsW[g])
    );
  end

  function automatic int waitOf(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  // Address/direction rules for an erroring access, independent of privilege
  function automatic logic expErr(input logic [31:0] addr, input logic wr);
    logic [31:0] off;
    if (addr < BASE) return 1'b1;
    off = addr - BASE;
    if (off >= 32'(4 * NR)) return 1'b1;
    if (addr % 4 != 0) return 1'b1;
    if (wr && (off / 4 == 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [32*NR-1:0] packModel(input int d);
    logic [32*NR-1:0] v;
    for (int k = 0; k < NR; k++) v[32*k +: 32] = model[d][k];
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [32*NR-1:0] obs, input logic [32*NR-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer on DUT d; leaves psel high so a next call is back-to-back
  task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [2:0] prot, output logic [31:0] rdata);
    logic        err;
    logic [31:0] off;
    int          idx;
    err = expErr(addr, wr);
    off = addr - BASE;
`ifdef APB_COMPLETER_PROT_EN
    if (!err && !prot[0] && ((off >> 2) >= NR / 2)) err = 1'b1;
`endif
    idx = err ? 0 : int'(off >> 2);
    @(posedge clock); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb; pprot[d] = prot;
    @(negedge clock);
    checkOutput($sformatf("d%0d setup pready", d), preadyW[d], 0);
    @(posedge clock); #1;
    penable[d] = 1'b1;
    for (int i = 0; i < waitOf(d); i++) begin
      @(negedge clock);
      checkOutput($sformatf("d%0d wait%0d pready", d, i), preadyW[d], 0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    checkOutput($sformatf("d%0d ready pready @%0h", d, addr), preadyW[d], 1);
    checkOutput($sformatf("d%0d pslverr @%0h", d, addr), pslverrW[d], err);
    rdata = prdataW[d];
    if (!wr) checkOutput($sformatf("d%0d prdata @%0h", d, addr), prdataW[d], err ? 32'h0 : model[d][idx]);
    if (wr && !err) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
    end
  endtask

  task automatic idleBus(input int d);
    @(posedge clock); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    @(negedge clock);
    checkOutput($sformatf("d%0d idle pready", d), preadyW[d], 0);
    checkOutput($sformatf("d%0d regs", d), regsW[d], packModel(d));
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] addr;
    int          sel;

    for (int d = 0; d < NDUT; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0;
      model[d][0] = IDV;
      for (int k = 1; k < NR; k++) model[d][k] = '0;
    end
    resetN = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("d%0d reset pready", d), preadyW[d], 0);
      checkOutput($sformatf("d%0d reset pslverr", d), pslverrW[d], 0);
      checkOutput($sformatf("d%0d reset prdata", d), prdataW[d], 0);
      checkOutput($sformatf("d%0d reset regs", d), regsW[d], packModel(d));
    end
    resetN = 1'b1;

    $display("[TB] zero-wait write/read and back-to-back read-after-write");
    applyStimulus(0, 1'b1, BASE + 4, 32'hDEAD_BEEF, 4'hF, 3'b001, rd);
    applyStimulus(0, 1'b0, BASE + 4, 32'h0, 4'h0, 3'b001, rd);
    checkOutput("d0 readback deadbeef", rd, 32'hDEAD_BEEF);
    idleBus(0);

    $display("[TB] partial strobe write");
    applyStimulus(0, 1'b1, BASE + 8, 32'h1122_3344, 4'hF, 3'b001, rd);
    applyStimulus(0, 1'b1, BASE + 8, 32'hAABB_CCDD, 4'b0101, 3'b001, rd);
    applyStimulus(0, 1'b0, BASE + 8, 32'h0, 4'h0, 3'b001, rd);
    checkOutput("d0 partial strobe", rd, 32'h11BB_33DD);
    applyStimulus(0, 1'b1, BASE + 8, 32'hFFFF_FFFF, 4'h0, 3'b001, rd);
    idleBus(0);

    $display("[TB] error accesses");
    applyStimulus(0, 1'b1, BASE + 0, 32'h1234_5678, 4'hF, 3'b001, rd);
    applyStimulus(0, 1'b0, BASE + 4 * NR, 32'h0, 4'h0, 3'b001, rd);
    checkOutput("d0 out-of-range prdata", rd, 32'h0);
    applyStimulus(0, 1'b1, BASE + 6, 32'h5A5A_5A5A, 4'hF, 3'b001, rd);
    applyStimulus(0, 1'b0, BASE - 4, 32'h0, 4'h0, 3'b001, rd);
    idleBus(0);

    $display("[TB] privilege on top register");
    applyStimulus(0, 1'b1, BASE + 4 * (NR - 1), 32'h0BAD_F00D, 4'hF, 3'b000, rd);
    applyStimulus(0, 1'b0, BASE + 4 * (NR - 1), 32'h0, 4'h0, 3'b001, rd);
    idleBus(0);

    $display("[TB] access phase without setup is ignored");
    @(posedge clock); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = BASE + 4;
    repeat (3) begin
      @(negedge clock);
      checkOutput("d0 stray penable pready", preadyW[0], 0);
    end
    idleBus(0);

    $display("[TB] three wait states reading ID");
    applyStimulus(2, 1'b0, BASE + 0, 32'h0, 4'h0, 3'b001, rd);
    checkOutput("d2 id value", rd, IDV);
    idleBus(2);

    $display("[TB] abort during first wait cycle");
    applyStimulus(1, 1'b1, BASE + 8, 32'h0102_0304, 4'hF, 3'b001, rd);
    idleBus(1);
    @(posedge clock); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = BASE + 8; pwdata[1] = 32'hCAFE_F00D; pstrb[1] = 4'hF; pprot[1] = 3'b001;
    @(posedge clock); #1;
    penable[1] = 1'b1;
    @(negedge clock);
    checkOutput("d1 abort wait pready", preadyW[1], 0);
    #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    applyStimulus(1, 1'b0, BASE + 8, 32'h0, 4'h0, 3'b001, rd);
    checkOutput("d1 reg2 after abort", rd, 32'h0102_0304);
    idleBus(1);

    $display("[TB] randomized transfers");
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 30; n++) begin
        sel = $urandom_range(0, 9);
        if (sel < 6)       addr = BASE + 4 * $urandom_range(0, NR - 1);
        else if (sel == 6) addr = BASE + 4 * $urandom_range(0, NR - 1) + $urandom_range(1, 3);
        else if (sel == 7) addr = BASE + 4 * NR + 4 * $urandom_range(0, 3);
        else if (sel == 8) addr = BASE - 4 * $urandom_range(1, 4);
        else               addr = BASE + 4 * (NR - 1);
        applyStimulus(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                      3'($urandom_range(0, 7)), rd);
        if ($urandom_range(0, 2) == 0) idleBus(d);
      end
      idleBus(d);
    end

    $display("[TB] reset during ready cycle");
    @(posedge clock); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = BASE + 12; pwdata[0] = 32'h7777_7777; pstrb[0] = 4'hF; pprot[0] = 3'b001;
    @(posedge clock); #1;
    penable[0] = 1'b1;
    @(negedge clock);
    checkOutput("d0 pre-reset pready", preadyW[0], 1);
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("d0 reset pready now", preadyW[0], 0);
    checkOutput("d0 reset pslverr now", pslverrW[0], 0);
    checkOutput("d0 reset prdata now", prdataW[0], 0);
    for (int d = 0; d < NDUT; d++) for (int k = 1; k < NR; k++) model[d][k] = '0;
    for (int d = 0; d < NDUT; d++) checkOutput($sformatf("d%0d regs after reset", d), regsW[d], packModel(d));
    psel[0] = 1'b0; penable[0] = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("d0 regs held in reset", regsW[0], packModel(0));
    resetN = 1'b1;
    applyStimulus(0, 1'b1, BASE + 12, 32'h8888_9999, 4'hF, 3'b001, rd);
    applyStimulus(0, 1'b0, BASE + 12, 32'h0, 4'h0, 3'b001, rd);
    checkOutput("d0 post-reset readback", rd, 32'h8888_9999);
    idleBus(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
